// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch sequencer. Issues 8-byte fetch packets to the ICache under
//            buffer credits, pairs in-order responses with their PC and drops
//            stale responses after a redirect.
//            Optional: FETCH_PERF_EN adds stall/drop performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int                       CPU_ADDR_BITS = 32,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC      = '0,
    parameter int                       BUF_DEPTH     = 8,
    parameter int                       MAX_INFLIGHT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_val,
    input  logic [CPU_ADDR_BITS-1:0] redirect_pc,
    output logic                     icache_req_val,
    output logic [CPU_ADDR_BITS-1:0] icache_req_addr,
    input  logic                     icache_req_rdy,
    input  logic                     icache_resp_val,
    output logic                     ibuf_wr_val,
    output logic [CPU_ADDR_BITS-1:0] ibuf_pc,
    input  logic                     ibuf_deq,
`ifdef FETCH_PERF_EN
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_dropped,
`endif
    output logic                     ibuf_flush
);

    localparam int c_OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int c_CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int c_PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int c_SUM_W = ((c_OCC_W > c_CNT_W) ? c_OCC_W : c_CNT_W) + 1;

    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [CPU_ADDR_BITS-1:0] r_fetch_pc;
    logic [c_OCC_W-1:0]       r_occ;
    logic [c_CNT_W-1:0]       r_inflight;
    logic [c_CNT_W-1:0]       r_drop_cnt;
    logic [c_PTR_W-1:0]       r_wptr;
    logic [c_PTR_W-1:0]       r_rptr;
    logic [CPU_ADDR_BITS-1:0] r_fifo [MAX_INFLIGHT];

    logic [c_CNT_W-1:0]       w_live;
    logic [c_SUM_W-1:0]       w_sum;
    logic                     w_credit_ok;
    logic                     w_slot_ok;
    logic                     w_req_val;
    logic                     w_wr_val;
    logic                     w_fire;
    logic [c_CNT_W-1:0]       w_redirect_drop;
    logic [CPU_ADDR_BITS-1:0] w_redirect_pc;
    logic                     w_unused;

    // Stale requests still occupy an ICache slot but will never consume a
    // buffer entry, so only live requests are charged against buffer credits.
    assign w_live          = r_inflight - r_drop_cnt;
    assign w_sum           = c_SUM_W'(r_occ) + c_SUM_W'(w_live);
    assign w_credit_ok     = w_sum < c_SUM_W'(BUF_DEPTH - 1);
    assign w_slot_ok       = r_inflight < c_CNT_W'(MAX_INFLIGHT);
    assign w_fire          = w_req_val && icache_req_rdy;
    assign w_redirect_drop = r_inflight - c_CNT_W'(icache_resp_val);
    assign w_redirect_pc   = {redirect_pc[CPU_ADDR_BITS-1:3], 3'b000};
    assign w_unused        = ^redirect_pc[2:0];

    assign icache_req_val  = w_req_val;
    assign icache_req_addr = r_fetch_pc;
    assign ibuf_wr_val     = w_wr_val;
    assign ibuf_pc         = r_fifo[r_rptr];
    assign ibuf_flush      = redirect_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_val   = 1'b0;
        w_wr_val    = 1'b0;
        case (r_state)
            c_BOOT: begin
                w_state_nxt = c_FETCH;
            end
            c_FETCH, c_DRAIN: begin
                w_req_val = !redirect_val && w_slot_ok && w_credit_ok;
                if ((r_state == c_DRAIN) && icache_resp_val &&
                    (r_drop_cnt == c_CNT_W'(1))) begin
                    w_state_nxt = c_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_BOOT;
            end
        endcase
        w_wr_val = icache_resp_val && !redirect_val && (r_drop_cnt == '0);
        if (redirect_val) begin
            w_state_nxt = (w_redirect_drop != '0) ? c_DRAIN : c_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_occ      <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (redirect_val) begin
                r_fetch_pc <= w_redirect_pc;
                r_occ      <= '0;
                r_drop_cnt <= w_redirect_drop;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + CPU_ADDR_BITS'(8);
                end
                if (w_wr_val && !ibuf_deq) begin
                    r_occ <= r_occ + c_OCC_W'(1);
                end else if (!w_wr_val && ibuf_deq) begin
                    r_occ <= r_occ - c_OCC_W'(1);
                end
                if (icache_resp_val && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                end
            end

            case ({w_fire, icache_resp_val})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (w_fire) begin
                r_wptr <= (r_wptr == c_PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            end
            // Every response pops, including dropped ones, so stale PCs drain out.
            if (icache_resp_val) begin
                r_rptr <= (r_rptr == c_PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_fifo[r_wptr] <= r_fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_drop;
    logic        w_stall;
    logic        w_dropped;

    assign w_stall   = ((r_state == c_FETCH) || (r_state == c_DRAIN)) &&
                       !w_req_val && !redirect_val;
    assign w_dropped = icache_resp_val && !w_wr_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_dropped && (r_perf_drop != '1)) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_dropped      = r_perf_drop;
`else
    // No performance counters in this build.
`endif

    a_resp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(icache_resp_val && (r_inflight == '0)));
    a_buffer_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_wr_val && (r_occ == c_OCC_W'(BUF_DEPTH - 1))));
    a_deq_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(ibuf_deq && (r_occ == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl: expected request addresses and
//            buffer-write PCs are queued by the stimulus, popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        icache_req_val;
    logic [31:0] icache_req_addr;
    logic        icache_req_rdy;
    logic        icache_resp_val;
    logic        ibuf_wr_val;
    logic [31:0] ibuf_pc;
    logic        ibuf_deq;
    logic        ibuf_flush;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dropped;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_count = 0;
    int          drops = 0;
    logic        last_fire = 1'b0;
    logic        auto_resp = 1'b0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_wr[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_val     (redirect_val),
        .redirect_pc      (redirect_pc),
        .icache_req_val   (icache_req_val),
        .icache_req_addr  (icache_req_addr),
        .icache_req_rdy   (icache_req_rdy),
        .icache_resp_val  (icache_resp_val),
        .ibuf_wr_val      (ibuf_wr_val),
        .ibuf_pc          (ibuf_pc),
        .ibuf_deq         (ibuf_deq),
`ifdef FETCH_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_dropped     (perf_dropped),
`endif
        .ibuf_flush       (ibuf_flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle: advance to just after the edge; the ICache model answers
    // every accepted request on the following cycle when auto_resp is set.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_resp) icache_resp_val = last_fire;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_fire = 1'b0;
        end else begin
            last_fire = icache_req_val && icache_req_rdy;
            chk("flush_follows_redirect", 32'(ibuf_flush), 32'(redirect_val));
            if (last_fire) begin
                req_count++;
                if (exp_req.size() == 0) chk("unexpected_request", icache_req_addr, 32'hDEAD_BEEF);
                else chk("request_addr", icache_req_addr, exp_req.pop_front());
            end
            if (ibuf_wr_val) begin
                if (exp_wr.size() == 0) chk("unexpected_write", ibuf_pc, 32'hDEAD_BEEF);
                else chk("write_pc", ibuf_pc, exp_wr.pop_front());
            end
            if (icache_resp_val && !ibuf_wr_val) drops++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        rst = 1'b1; redirect_val = 1'b0; redirect_pc = '0;
        icache_req_rdy = 1'b1; icache_resp_val = 1'b0; ibuf_deq = 1'b0;
        auto_resp = 1'b1;
        tick(); tick();
        #1;
        chk("reset_req_val", 32'(icache_req_val), 0);
        chk("reset_req_addr", icache_req_addr, 32'h0);
        chk("reset_wr_val", 32'(ibuf_wr_val), 0);
        chk("reset_flush", 32'(ibuf_flush), 0);

        // Fill: 7 packets issue and are written, then credits run out.
        for (int i = 0; i < 7; i++) begin
            exp_req.push_back(32'(i * 8));
            exp_wr.push_back(32'(i * 8));
        end
        rst = 1'b0;
        #1;
        chk("boot_req_val", 32'(icache_req_val), 0);
        repeat (12) tick();
        #1;
        chk("fill_req_count", req_count, 7);
        chk("fill_stalled", 32'(icache_req_val), 0);
        chk("fill_req_q_empty", exp_req.size(), 0);
        chk("fill_wr_q_empty", exp_wr.size(), 0);

        // One dequeue frees one credit, usable only on the next cycle.
        ibuf_deq = 1'b1;
        exp_req.push_back(32'h38);
        exp_wr.push_back(32'h38);
        #1;
        chk("deq_same_cycle_no_issue", 32'(icache_req_val), 0);
        tick();
        ibuf_deq = 1'b0;
        #1;
        chk("deq_next_req_val", 32'(icache_req_val), 1);
        chk("deq_next_req_addr", icache_req_addr, 32'h38);
        repeat (4) tick();
        #1;
        chk("deq_req_count", req_count, 8);
        chk("deq_restalled", 32'(icache_req_val), 0);

        // Empty the buffer with issue blocked, then put 3 requests in flight.
        icache_req_rdy = 1'b0;
        ibuf_deq = 1'b1;
        repeat (7) tick();
        ibuf_deq = 1'b0;
        auto_resp = 1'b0;
        icache_resp_val = 1'b0;
        exp_req.push_back(32'h40); exp_req.push_back(32'h48); exp_req.push_back(32'h50);
        icache_req_rdy = 1'b1;
        tick(); tick(); tick();
        icache_req_rdy = 1'b0;

        redirect_val = 1'b1;
        redirect_pc = 32'h104;
        #1;
        chk("redir3_flush", 32'(ibuf_flush), 1);
        chk("redir3_req_val", 32'(icache_req_val), 0);
        tick();
        redirect_val = 1'b0;
        #1;
        chk("drain_addr", icache_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            icache_resp_val = 1'b1;
            #1;
            chk("drain_drop_wr_val", 32'(ibuf_wr_val), 0);
            tick();
        end
        icache_resp_val = 1'b0;
        #1;
        chk("drain_drop_count", drops, 3);
`ifdef FETCH_PERF_EN
        chk("perf_dropped_3", perf_dropped, 3);
`endif
        auto_resp = 1'b1;
        icache_req_rdy = 1'b1;
        exp_req.push_back(32'h100);
        exp_wr.push_back(32'h100);
        #1;
        chk("post_drain_req_val", 32'(icache_req_val), 1);
        chk("post_drain_req_addr", icache_req_addr, 32'h100);
        tick();
        icache_req_rdy = 1'b0;
        tick(); tick();

        // Redirect together with a response: only one further response is stale.
        auto_resp = 1'b0;
        exp_req.push_back(32'h108); exp_req.push_back(32'h110);
        icache_req_rdy = 1'b1;
        tick(); tick();
        icache_req_rdy = 1'b0;
        redirect_val = 1'b1;
        redirect_pc = 32'h200;
        icache_resp_val = 1'b1;
        #1;
        chk("redir_resp_wr_val", 32'(ibuf_wr_val), 0);
        chk("redir_resp_flush", 32'(ibuf_flush), 1);
        tick();
        redirect_val = 1'b0;
        #1;
        chk("redir_resp_drop_wr_val", 32'(ibuf_wr_val), 0);
        tick();
        icache_resp_val = 1'b0;
        auto_resp = 1'b1;
        icache_req_rdy = 1'b1;
        exp_req.push_back(32'h200);
        exp_wr.push_back(32'h200);
        #1;
        chk("redir_resp_next_addr", icache_req_addr, 32'h200);
        tick();
        icache_req_rdy = 1'b0;
        tick(); tick();
        #1;
        chk("redir_resp_drops", drops, 5);

        // Back-pressure: request stays valid and stable until rdy rises.
        rc = req_count;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req_val", 32'(icache_req_val), 1);
            chk("stall_req_addr", icache_req_addr, 32'h208);
            tick();
        end
        chk("stall_no_handshake", req_count, rc);
        exp_req.push_back(32'h208);
        exp_wr.push_back(32'h208);
        icache_req_rdy = 1'b1;
        tick();
        icache_req_rdy = 1'b0;
        tick(); tick();

        // Unaligned redirect target near the top of the address space wraps.
        redirect_val = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_val = 1'b0;
        exp_req.push_back(32'hFFFF_FFF8); exp_req.push_back(32'h0);
        exp_wr.push_back(32'hFFFF_FFF8);  exp_wr.push_back(32'h0);
        icache_req_rdy = 1'b1;
        #1;
        chk("wrap_first_addr", icache_req_addr, 32'hFFFF_FFF8);
        tick();
        #1;
        chk("wrap_second_addr", icache_req_addr, 32'h0);
        tick();
        icache_req_rdy = 1'b0;
        tick(); tick(); tick();

        #1;
        chk("final_req_q_empty", exp_req.size(), 0);
        chk("final_wr_q_empty", exp_wr.size(), 0);
        chk("final_drops", drops, 5);
`ifdef FETCH_PERF_EN
        chk("final_perf_dropped", perf_dropped, 5);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end sequencer between the PC, the ICache and the two-instruction fetch buffer.
- Generates 8-byte-aligned fetch-packet addresses, issues them to the ICache with a val/rdy handshake, and tracks in-flight requests.
- Flow control is credit-based: the buffer can never overflow.
- Pairs each in-order ICache response with its fetch PC for the buffer write, flushes the buffer on redirect, and silently drops stale responses.

Parameters:
- RESET_PC, 'h0000_0000, fetch address issued after reset; must be 8-byte aligned.
- BUF_DEPTH, 8, inst buffer depth (power of 2); usable entries = BUF_DEPTH-1.
- MAX_INFLIGHT, 4, max outstanding ICache requests, stale ones included; sets the address-FIFO depth.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_val  in  1  branch/exception redirect
- redirect_pc  in  CPU_ADDR_BITS  redirect target; bits [2:0] ignored (treated as 0)
- icache_req_val  out  1  fetch request valid
- icache_req_addr  out  CPU_ADDR_BITS  fetch packet address, bits [2:0]=0
- icache_req_rdy  in  1  ICache accepts request
- icache_resp_val  in  1  ICache data valid; responses return in request order
- ibuf_wr_val  out  1  drives buffer write-valid (icache_dout_val)
- ibuf_pc  out  CPU_ADDR_BITS  PC of the packet being written
- ibuf_deq  in  1  buffer dequeue this cycle (decoder_rdy && inst_val)
- ibuf_flush  out  1  buffer flush

Behaviour:
- Reset (synchronous, active-high; clk and rst only):
  - Outputs: icache_req_val=0, ibuf_wr_val=0, ibuf_flush=0, icache_req_addr=RESET_PC.
  - State: fetch_pc=RESET_PC, occ=0, inflight=0, drop_cnt=0, FIFO empty, state=BOOT.
  - rst mid-operation discards everything; responses to pre-reset requests are outside this block's contract.
- States:
  - BOOT: req_val=0 for one cycle, then FETCH.
  - FETCH: normal issue.
  - DRAIN: drop_cnt>0; new requests may still issue. Return to FETCH when drop_cnt decrements to 0.
- Issue condition: icache_req_val = (state!=BOOT) && !redirect_val && (inflight<MAX_INFLIGHT) && (occ+live<BUF_DEPTH-1).
  - live = inflight-drop_cnt.
  - icache_req_addr = fetch_pc.
  - Request is combinational from registered state; no dependence on icache_req_rdy.
- Handshake (val&&rdy):
  - Push fetch_pc into address FIFO, inflight+1, fetch_pc += 8.
  - Wrap at 2^CPU_ADDR_BITS, no overflow flag.
  - icache_req_addr is held stable while val && !rdy.
- Response:
  - Pop FIFO, inflight-1.
  - If drop_cnt==0: ibuf_wr_val=1 same cycle (combinational), ibuf_pc=FIFO head, occ+1.
  - Else: drop the response, ibuf_wr_val=0, drop_cnt-1.
- occ: +1 on accepted write, -1 on ibuf_deq; simultaneous +1/-1 leaves it unchanged.
- Redirect, highest priority, same cycle:
  - ibuf_flush=1 (combinational = redirect_val), icache_req_val=0, ibuf_wr_val=0.
  - Next state: fetch_pc=redirect_pc&~7, occ=0.
  - drop_cnt = inflight minus 1 if a response also arrives this cycle; that response is popped and dropped.
  - state = DRAIN if new drop_cnt>0, else FETCH.
  - Redirect in DRAIN recomputes drop_cnt the same way. Redirect in BOOT is honoured.
  - FIFO is not cleared; stale entries drain through pops.
- Boundaries:
  - occ+live==BUF_DEPTH-1 stalls issue; a same-cycle ibuf_deq frees a credit only on the next cycle.
  - inflight==MAX_INFLIGHT stalls issue; a same-cycle response frees the slot only on the next cycle.
  - Handshake and response in the same cycle: push and pop both occur; inflight unchanged.
  - ibuf_deq while occ==0 is illegal.
- Assertions: icache_resp_val with inflight==0; ibuf_wr_val && occ==BUF_DEPTH-1.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cycles (32b): counts cycles in FETCH/DRAIN with icache_req_val=0 and no redirect.
  - perf_dropped (32b): counts dropped responses.
  - Both counters saturate at all-ones and clear on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, rdy=1, ICache returns one response per cycle after a 1-cycle latency, no deq:
  - Requests issued at 0x0, 0x8, … 0x30 (7 total).
  - Writes carry ibuf_pc 0x0 … 0x30.
  - Issue then stalls with occ=7.
- Continue from the stalled state, pulse ibuf_deq once: exactly one new request, at 0x38, on the cycle after the deq.
- 3 requests in flight, redirect_pc=0x104 with no response that cycle:
  - ibuf_flush=1 that cycle; state goes to DRAIN.
  - Next 3 responses are dropped, with ibuf_wr_val=0 on each.
  - Next request is at 0x100; the first write after drain has ibuf_pc=0x100.
- Redirect coincident with a response (2 in flight): drop_cnt=1; only one more response is dropped.
- icache_req_rdy held 0 for 5 cycles: val stays 1 and addr stays constant; inflight is unchanged until rdy rises.
- With FETCH_PERF_EN, rerun the redirect case with 3 in flight: perf_dropped=3.
